// File: rtl/fetch_decode_queue.sv
// Elastic fetch/decode queue: DEPTH-entry circular buffer of {pc, instr}
// with valid/ready on both sides and a flush that squashes everything.
module fetch_decode_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CW        = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [XLEN-1:0] out_instr,
    output logic [CW-1:0]   count
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic push;
    logic pop;
    logic nonempty;

    // Explicit wrap so non-power-of-two depths cycle correctly
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign nonempty = (cnt_q != '0);
    assign in_ready = (cnt_q != FULL);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = out_valid & out_ready;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wrap_inc(wp_q);
            if (pop)  rp_d = wrap_inc(rp_q);
            if (push & ~pop)
                cnt_d = cnt_q + CW'(1);
            else if (pop & ~push)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wp_q]    <= in_pc;
            instr_mem_q[wp_q] <= in_instr;
        end
    end

    assign out_valid     = nonempty & ~flush;
    assign out_instr     = out_valid ? instr_mem_q[rp_q] : NOP_INSTR;
    assign out_pc        = nonempty ? pc_mem_q[rp_q] : '0;
    assign out_pc_plus_4 = out_pc + XLEN'(4);
    assign count         = cnt_q;

endmodule
